// File: rtl/rtf65002_itag_assoc_if.sv
// Fetch / fill-controller bundle for the set-associative itag array.
// The master side (fetch unit plus fill controller) drives addresses and strobes.
// The slave side (the tag array) returns hits, way selects and busy.
interface rtf65002_itag_assoc_if #(
    parameter int AW = 32,
    parameter int WW = 1
);
    logic [AW-1:0] pc_i;
    logic          hit0_o;
    logic          hit1_o;
    logic [WW-1:0] way0_o;
    logic [WW-1:0] way1_o;
    logic          fill_i;
    logic [AW-1:0] fill_adr_i;
    logic [WW-1:0] fill_way_o;
    logic          inv_line_i;
    logic [AW-1:0] inv_adr_i;
    logic          inv_all_i;
    logic          busy_o;

    modport master (
        output pc_i, fill_i, fill_adr_i, inv_line_i, inv_adr_i, inv_all_i,
        input  hit0_o, hit1_o, way0_o, way1_o, fill_way_o, busy_o
    );

    modport slave (
        input  pc_i, fill_i, fill_adr_i, inv_line_i, inv_adr_i, inv_all_i,
        output hit0_o, hit1_o, way0_o, way1_o, fill_way_o, busy_o
    );
endinterface

// File: rtl/rtf65002_itag_assoc.sv
// Set-associative instruction-cache tag array.
// Two lookups per cycle (pc and pc+LOOKAHEAD), round-robin fills that prefer
// invalid ways, single-line invalidate and a one-set-per-cycle invalidate-all sweep.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | normal operation: lookups, fills and line invalidates accepted
// ST_SWEEP | clearing set cnt in every way each cycle; busy, hits forced to 0
module rtf65002_itag_assoc #(
    parameter int AW         = 32,
    parameter int LINE_BYTES = 16,
    parameter int SETS       = 512,
    parameter int WAYS       = 2,
    parameter int LOOKAHEAD  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    rtf65002_itag_assoc_if.slave bus
);
    localparam int OFS  = $clog2(LINE_BYTES);
    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = AW - IDX - OFS;
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    logic [0:0]      state;
    logic [IDX-1:0]  cnt;
    logic            post_q;

    // Tag RAM per way: {tag, valid}; not reset, the sweep cleans it.
    logic [TAGW:0]   mem [WAYS][SETS];
    logic [TAGW:0]   rd0 [WAYS];
    logic [TAGW:0]   rd1 [WAYS];
    logic [TAGW-1:0] tag0_q;
    logic [TAGW-1:0] tag1_q;

    // Flop copies of the valid bits and the round-robin pointers, so that
    // replacement-way selection is available combinationally.
    logic [WAYS-1:0] vshadow [SETS];
    logic [WW-1:0]   ptr [SETS];

    logic [AW-1:0]   pcp;
    logic [IDX-1:0]  idx0, idx1, fill_idx, inv_idx;
    logic [TAGW-1:0] fill_tag, inv_tag;
    logic            busy, sweep_clr, do_inv, do_fill;
    logic [WAYS-1:0] inv_match;
    logic [WAYS-1:0] fill_mask;
    logic [WW-1:0]   fill_way, ptr_nxt;
    logic            hit0, hit1;
    logic [WW-1:0]   way0, way1;
    logic            unused_ofs;

    assign pcp      = bus.pc_i + AW'(LOOKAHEAD);
    assign idx0     = bus.pc_i[IDX+OFS-1:OFS];
    assign idx1     = pcp[IDX+OFS-1:OFS];
    assign fill_idx = bus.fill_adr_i[IDX+OFS-1:OFS];
    assign fill_tag = bus.fill_adr_i[AW-1:IDX+OFS];
    assign inv_idx  = bus.inv_adr_i[IDX+OFS-1:OFS];
    assign inv_tag  = bus.inv_adr_i[AW-1:IDX+OFS];

    assign unused_ofs = ^{bus.pc_i[OFS-1:0], pcp[OFS-1:0],
                          bus.fill_adr_i[OFS-1:0], bus.inv_adr_i[OFS-1:0]};

    // The cycle after the last clear stays busy so registered hits are clean.
    assign busy      = (state == ST_SWEEP) | post_q;
    assign sweep_clr = (state == ST_SWEEP);
    assign do_inv    = bus.inv_line_i & ~busy & ~bus.inv_all_i;
    assign do_fill   = bus.fill_i & ~busy & ~bus.inv_all_i & ~bus.inv_line_i;

    // Ways of the invalidate set holding a valid copy of the target line.
    always_comb begin
        inv_match = '0;
        for (int w = 0; w < WAYS; w++) begin
            inv_match[w] = vshadow[inv_idx][w] && (mem[w][inv_idx][TAGW:1] == inv_tag);
        end
    end

    // Replacement way: lowest invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        fill_way = ptr[fill_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!vshadow[fill_idx][w]) fill_way = WW'(w);
        end
    end

    assign ptr_nxt   = (ptr[fill_idx] == WW'(WAYS - 1)) ? '0 : ptr[fill_idx] + 1'b1;
    assign fill_mask = WAYS'(1) << fill_way;

    // Hit detection on registered RAM output; lowest matching way wins.
    always_comb begin
        hit0 = 1'b0;
        hit1 = 1'b0;
        way0 = '0;
        way1 = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (rd0[w][0] && (rd0[w][TAGW:1] == tag0_q)) begin
                hit0 = 1'b1;
                way0 = WW'(w);
            end
            if (rd1[w][0] && (rd1[w][TAGW:1] == tag1_q)) begin
                hit1 = 1'b1;
                way1 = WW'(w);
            end
        end
    end

    assign bus.hit0_o     = hit0 & ~busy;
    assign bus.hit1_o     = hit1 & ~busy;
    assign bus.way0_o     = busy ? '0 : way0;
    assign bus.way1_o     = busy ? '0 : way1;
    assign bus.fill_way_o = fill_way;
    assign bus.busy_o     = busy;

    // Tag RAM: read-first synchronous reads for both lookups, one write per way.
    always_ff @(posedge clk_i) begin
        tag0_q <= bus.pc_i[AW-1:IDX+OFS];
        tag1_q <= pcp[AW-1:IDX+OFS];
        for (int w = 0; w < WAYS; w++) begin
            rd0[w] <= mem[w][idx0];
            rd1[w] <= mem[w][idx1];
            if (sweep_clr) begin
                mem[w][cnt] <= '0;
            end else if (do_inv && inv_match[w]) begin
                mem[w][inv_idx] <= {mem[w][inv_idx][TAGW:1], 1'b0};
            end else if (do_fill && (fill_way == WW'(w))) begin
                mem[w][fill_idx] <= {fill_tag, 1'b1};
            end
        end
    end

    // Shadow valid bits and round-robin pointers track every RAM update.
    always_ff @(posedge clk_i) begin
        if (sweep_clr) begin
            vshadow[cnt] <= '0;
            ptr[cnt]     <= '0;
        end else if (do_inv) begin
            vshadow[inv_idx] <= vshadow[inv_idx] & ~inv_match;
        end else if (do_fill) begin
            vshadow[fill_idx] <= vshadow[fill_idx] | fill_mask;
            ptr[fill_idx]     <= ptr_nxt;
        end
    end

    // Sweep sequencer: reset and inv_all both (re)start a full pass from set 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= ST_SWEEP;
            cnt    <= '0;
            post_q <= 1'b0;
        end else begin
            post_q <= 1'b0;
            if (bus.inv_all_i) begin
                state <= ST_SWEEP;
                cnt   <= '0;
            end else if (state == ST_SWEEP) begin
                if (cnt == IDX'(SETS - 1)) begin
                    state  <= ST_IDLE;
                    post_q <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rtf65002_itag_assoc.sv
// Bench for rtf65002_itag_assoc: directed and random stimulus, reference model
// of per-set ways/pointers, scoreboard queue drained by a separate monitor.
module tb_rtf65002_itag_assoc;
    localparam int AW    = 32;
    localparam int LINE  = 16;
    localparam int SETS  = 512;
    localparam int WAYS  = 2;
    localparam int LA    = 8;
    localparam int WW    = 1;
    localparam int OFS   = 4;
    localparam int IDX   = 9;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;

    rtf65002_itag_assoc_if #(.AW(AW), .WW(WW)) bus ();

    rtf65002_itag_assoc #(
        .AW(AW), .LINE_BYTES(LINE), .SETS(SETS), .WAYS(WAYS), .LOOKAHEAD(LA)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit busy;
        bit h0;
        int w0;
        bit h1;
        int w1;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    // Reference model: per set, per way valid/tag, plus round-robin pointer.
    bit        m_valid [SETS][WAYS];
    bit [31:0] m_tag   [SETS][WAYS];
    int        m_ptr   [SETS];
    int        busy_rem;

    function automatic int set_of(input bit [31:0] a);
        return int'((a >> OFS) % SETS);
    endfunction

    function automatic bit [31:0] tag_of(input bit [31:0] a);
        return a >> (OFS + IDX);
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_tag[s][w]   = '0;
            end
        end
    endfunction

    function automatic void m_lookup(input bit [31:0] a, output bit h, output int way);
        int s;
        s = set_of(a);
        h = 1'b0;
        way = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (!h && m_valid[s][w] && m_tag[s][w] == tag_of(a)) begin
                h = 1'b1;
                way = w;
            end
        end
    endfunction

    function automatic int m_fillway(input bit [31:0] a);
        int s;
        s = set_of(a);
        for (int w = 0; w < WAYS; w++) begin
            if (!m_valid[s][w]) return w;
        end
        return m_ptr[s];
    endfunction

    // One clock of stimulus: drive at posedge+2, advance model at the edge.
    task automatic step(input bit [31:0] pc, input bit fill, input bit [31:0] fa,
                        input bit invl, input bit [31:0] ia, input bit inva);
        exp_t e;
        bit h0, h1;
        int w0, w1, fw, s;
        bit busy_pre;
        bus.pc_i       = pc;
        bus.fill_i     = fill;
        bus.fill_adr_i = fa;
        bus.inv_line_i = invl;
        bus.inv_adr_i  = ia;
        bus.inv_all_i  = inva;
        #1;
        if (busy_rem == 0) begin
            n_cmp++;
            if (int'(bus.fill_way_o) != m_fillway(fa)) begin
                n_err++;
                $display("FAIL fill_way adr=%h got=%0d want=%0d", fa, bus.fill_way_o, m_fillway(fa));
            end
        end
        @(posedge clk_i);
        m_lookup(pc, h0, w0);
        m_lookup(pc + 32'd8, h1, w1);
        busy_pre = (busy_rem > 0);
        if (inva) begin
            m_clear();
            busy_rem = SETS + 1;
        end else if (busy_pre) begin
            busy_rem--;
        end else if (invl) begin
            s = set_of(ia);
            for (int w = 0; w < WAYS; w++)
                if (m_valid[s][w] && m_tag[s][w] == tag_of(ia)) m_valid[s][w] = 1'b0;
        end else if (fill) begin
            s  = set_of(fa);
            fw = m_fillway(fa);
            m_valid[s][fw] = 1'b1;
            m_tag[s][fw]   = tag_of(fa);
            m_ptr[s]       = (m_ptr[s] + 1) % WAYS;
        end
        e.busy = (busy_rem > 0);
        e.h0 = e.busy ? 1'b0 : h0;
        e.w0 = e.busy ? 0 : w0;
        e.h1 = e.busy ? 1'b0 : h1;
        e.w1 = e.busy ? 0 : w1;
        exp_q.push_back(e);
        #2;
    endtask

    task automatic idle(input bit [31:0] pc, input int n);
        for (int i = 0; i < n; i++) step(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if (bus.busy_o !== 1'b1 || bus.hit0_o !== 1'b0 || bus.hit1_o !== 1'b0 ||
            bus.way0_o !== '0 || bus.way1_o !== '0) begin
            n_err++;
            $display("FAIL %s busy=%b hit0=%b hit1=%b way0=%0d way1=%0d want busy=1 others=0",
                     tag, bus.busy_o, bus.hit0_o, bus.hit1_o, bus.way0_o, bus.way1_o);
        end
    endtask

    function automatic bit [31:0] rand_adr();
        bit [31:0] t, s;
        int k;
        k = $urandom_range(0, 4);
        t = (k == 4) ? 32'h7FFFF : 32'(k);
        case ($urandom_range(0, 3))
            0: s = 0;
            1: s = 1;
            2: s = 5;
            default: s = SETS - 1;
        endcase
        return (t << (OFS + IDX)) | (s << OFS) | 32'($urandom_range(0, LINE - 1));
    endfunction

    // Monitor: pops one expectation per cycle and compares at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (mon_en && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (bus.busy_o !== e.busy || bus.hit0_o !== e.h0 || bus.hit1_o !== e.h1 ||
                    int'(bus.way0_o) != e.w0 || int'(bus.way1_o) != e.w1) begin
                    n_err++;
                    $display("FAIL lookup t=%0t got busy=%b h0=%b w0=%0d h1=%b w1=%0d want busy=%b h0=%b w0=%0d h1=%b w1=%0d",
                             $time, bus.busy_o, bus.hit0_o, bus.way0_o, bus.hit1_o, bus.way1_o,
                             e.busy, e.h0, e.w0, e.h1, e.w1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [31:0] a;
        int r;
        bus.pc_i = 32'h1000; bus.fill_i = 0; bus.fill_adr_i = 0;
        bus.inv_line_i = 0; bus.inv_adr_i = 0; bus.inv_all_i = 0;
        m_clear();
        busy_rem = SETS + 1;
        repeat (3) @(posedge clk_i);
        #2;
        check_reset_outputs("reset_state");
        rst_ni = 1'b1;
        mon_en = 1'b1;

        // Initial sweep: busy for SETS+1 cycles with pc held at 0x1000.
        idle(32'h1000, SETS + 3);

        // Single fill and both lookups in the same line.
        step(32'h1000, 1, 32'h00001230, 0, 0, 0);
        step(32'h00001234, 0, 0, 0, 0, 0);
        step(32'h00001230, 0, 0, 0, 0, 0);

        // Same-set fills exercise invalid-first then round-robin selection.
        step(32'h1000, 1, 32'h00003230, 0, 0, 0);
        step(32'h1000, 1, 32'h00005230, 0, 0, 0);
        step(32'h00001230, 0, 0, 0, 0, 0);
        step(32'h00003230, 0, 0, 0, 0, 0);
        step(32'h00005230, 0, 0, 0, 0, 0);

        // Read-first collision, then line invalidate.
        step(32'h00007770, 1, 32'h00007770, 0, 0, 0);
        step(32'h00007770, 0, 0, 0, 0, 0);
        step(32'h00007770, 0, 0, 1, 32'h00007774, 0);
        step(32'h00007770, 0, 0, 0, 0, 0);
        step(32'h00007770, 0, 0, 0, 0, 0);

        // Lookahead wrap past the top of the address space.
        step(32'h1000, 1, 32'h00000000, 0, 0, 0);
        step(32'hFFFFFFFC, 0, 0, 0, 0, 0);
        step(32'hFFFFFFF0, 0, 0, 0, 0, 0);

        // Randomised traffic with occasional full invalidates.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            a = rand_adr();
            step(rand_adr(), (r < 45), a, (r >= 45 && r < 57), a,
                 ($urandom_range(0, 999) == 0));
        end

        // inv_all with a fill in the same cycle drops the fill.
        step(32'h1000, 1, 32'h00009990, 0, 0, 1);
        idle(32'h00009990, 101);

        // Reset in the middle of the sweep restarts it from scratch.
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("reset_mid_sweep");
        mon_en = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #2;
        check_reset_outputs("reset_held");
        m_clear();
        busy_rem = SETS + 1;
        rst_ni = 1'b1;
        mon_en = 1'b1;
        idle(32'h00009990, SETS + 3);
        step(32'h00009990, 1, 32'h00009990, 0, 0, 0);
        step(32'h00009990, 0, 0, 0, 0, 0);
        idle(32'h00009994, 2);

        @(negedge clk_i);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
